// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline widths and the ID/EX payload bundle for the 16-bit microRISC core.
package id_ex_reg_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned IMM_W      = 6;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned REG_DST_W  = 2;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_DST_W-1:0]  reg_dst;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     reg1_data;
    logic [DATA_W-1:0]     reg2_data;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [IMM_W-1:0]      imm;
  } id_ex_bundle_t;

  localparam int unsigned BUNDLE_W = $bits(id_ex_bundle_t);

endpackage

// File: rtl/pipe_dff.sv
// Generic pipeline register with synchronous reset and synchronous clear (bubble insert).
module pipe_dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset and clear both produce zeros, so they share one branch.
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else            q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: latches the decoded bundle each cycle; flush zeroes it into a NOP.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DATA_W     = id_ex_reg_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = id_ex_reg_pkg::REG_ADDR_W,
  parameter int unsigned IMM_W      = id_ex_reg_pkg::IMM_W,
  parameter int unsigned ALU_OP_W   = id_ex_reg_pkg::ALU_OP_W,
  parameter int unsigned REG_DST_W  = id_ex_reg_pkg::REG_DST_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [REG_DST_W-1:0]  id_reg_dst,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_reg1_data,
  input  logic [DATA_W-1:0]     id_reg2_data,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [IMM_W-1:0]      id_imm,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [REG_DST_W-1:0]  ex_reg_dst,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_reg1_data,
  output logic [DATA_W-1:0]     ex_reg2_data,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [IMM_W-1:0]      ex_imm
);

  id_ex_bundle_t id_bundle;
  id_ex_bundle_t ex_bundle;

  always_comb begin
    id_bundle            = '0;
    id_bundle.reg_write  = id_reg_write;
    id_bundle.mem_read   = id_mem_read;
    id_bundle.mem_write  = id_mem_write;
    id_bundle.mem_to_reg = id_mem_to_reg;
    id_bundle.alu_src    = id_alu_src;
    id_bundle.alu_op     = id_alu_op;
    id_bundle.reg_dst    = id_reg_dst;
    id_bundle.pc         = id_pc;
    id_bundle.reg1_data  = id_reg1_data;
    id_bundle.reg2_data  = id_reg2_data;
    id_bundle.rs         = id_rs;
    id_bundle.rt         = id_rt;
    id_bundle.rd         = id_rd;
    id_bundle.imm        = id_imm;
  end

  // One register across the whole bundle keeps every field in lockstep on flush.
  pipe_dff #(
    .W (BUNDLE_W)
  ) u_bundle_dff (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .d   (id_bundle),
    .q   (ex_bundle)
  );

  // Outputs are plain wires off the flops.
  assign ex_reg_write  = ex_bundle.reg_write;
  assign ex_mem_read   = ex_bundle.mem_read;
  assign ex_mem_write  = ex_bundle.mem_write;
  assign ex_mem_to_reg = ex_bundle.mem_to_reg;
  assign ex_alu_src    = ex_bundle.alu_src;
  assign ex_alu_op     = ex_bundle.alu_op;
  assign ex_reg_dst    = ex_bundle.reg_dst;
  assign ex_pc         = ex_bundle.pc;
  assign ex_reg1_data  = ex_bundle.reg1_data;
  assign ex_reg2_data  = ex_bundle.reg2_data;
  assign ex_rs         = ex_bundle.rs;
  assign ex_rt         = ex_bundle.rt;
  assign ex_rd         = ex_bundle.rd;
  assign ex_imm        = ex_bundle.imm;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, propagation, flush, priority and streaming.
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  id_ex_bundle_t in_b;
  id_ex_bundle_t obs_b;
  id_ex_bundle_t exp_b;

  logic                  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [ALU_OP_W-1:0]   ex_alu_op;
  logic [REG_DST_W-1:0]  ex_reg_dst;
  logic [DATA_W-1:0]     ex_pc, ex_reg1_data, ex_reg2_data;
  logic [REG_ADDR_W-1:0] ex_rs, ex_rt, ex_rd;
  logic [IMM_W-1:0]      ex_imm;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .id_reg_write  (in_b.reg_write),
    .id_mem_read   (in_b.mem_read),
    .id_mem_write  (in_b.mem_write),
    .id_mem_to_reg (in_b.mem_to_reg),
    .id_alu_src    (in_b.alu_src),
    .id_alu_op     (in_b.alu_op),
    .id_reg_dst    (in_b.reg_dst),
    .id_pc         (in_b.pc),
    .id_reg1_data  (in_b.reg1_data),
    .id_reg2_data  (in_b.reg2_data),
    .id_rs         (in_b.rs),
    .id_rt         (in_b.rt),
    .id_rd         (in_b.rd),
    .id_imm        (in_b.imm),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .ex_reg_dst    (ex_reg_dst),
    .ex_pc         (ex_pc),
    .ex_reg1_data  (ex_reg1_data),
    .ex_reg2_data  (ex_reg2_data),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_imm        (ex_imm)
  );

  always_comb begin
    obs_b            = '0;
    obs_b.reg_write  = ex_reg_write;
    obs_b.mem_read   = ex_mem_read;
    obs_b.mem_write  = ex_mem_write;
    obs_b.mem_to_reg = ex_mem_to_reg;
    obs_b.alu_src    = ex_alu_src;
    obs_b.alu_op     = ex_alu_op;
    obs_b.reg_dst    = ex_reg_dst;
    obs_b.pc         = ex_pc;
    obs_b.reg1_data  = ex_reg1_data;
    obs_b.reg2_data  = ex_reg2_data;
    obs_b.rs         = ex_rs;
    obs_b.rt         = ex_rt;
    obs_b.rd         = ex_rd;
    obs_b.imm        = ex_imm;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bundle(input string tag, input id_ex_bundle_t exp);
    tests_run++;
    assert (obs_b === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs_b, exp);
    end
  endtask

  task automatic check_pc(input string tag, input logic [DATA_W-1:0] exp);
    tests_run++;
    assert (ex_pc === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed ex_pc %h expected %h", tag, ex_pc, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    in_b  = '0;
    in_b.pc        = 16'hDEAD;
    in_b.reg1_data = 16'hBEEF;
    in_b.reg_write = 1'b1;
    in_b.imm       = 6'h2A;
    @(negedge clk);

    // Reset with arbitrary inputs applied
    tick();
    check_bundle("reset", '0);

    // Normal propagation, first edge after reset deasserts
    rst  = 1'b0;
    in_b = '0;
    in_b.reg_write = 1'b1;
    in_b.mem_read  = 1'b1;
    in_b.alu_op    = 4'b0101;
    in_b.pc        = 16'h1234;
    in_b.reg1_data = 16'hABCD;
    in_b.rs        = 3'b101;
    exp_b = '0;
    exp_b.reg_write = 1'b1;
    exp_b.mem_read  = 1'b1;
    exp_b.alu_op    = 4'b0101;
    exp_b.pc        = 16'h1234;
    exp_b.reg1_data = 16'hABCD;
    exp_b.rs        = 3'b101;
    tick();
    check_bundle("propagate", exp_b);

    // Flush zeroes every field, then reload
    flush = 1'b1;
    tick();
    check_bundle("flush", '0);
    flush = 1'b0;
    tick();
    check_bundle("reload", exp_b);
    check_pc("reload_pc", 16'h1234);

    // All-ones on every field, then all zeros
    in_b = '1;
    tick();
    check_bundle("all_ones", {BUNDLE_W{1'b1}});
    in_b = '0;
    tick();
    check_bundle("all_zeros", '0);

    // Mixed pattern on the remaining fields
    in_b = '0;
    in_b.mem_write  = 1'b1;
    in_b.mem_to_reg = 1'b1;
    in_b.alu_src    = 1'b1;
    in_b.reg_dst    = 2'b10;
    in_b.reg2_data  = 16'h5AA5;
    in_b.rt         = 3'b011;
    in_b.rd         = 3'b110;
    in_b.imm        = 6'h15;
    exp_b = '0;
    exp_b.mem_write  = 1'b1;
    exp_b.mem_to_reg = 1'b1;
    exp_b.alu_src    = 1'b1;
    exp_b.reg_dst    = 2'b10;
    exp_b.reg2_data  = 16'h5AA5;
    exp_b.rt         = 3'b011;
    exp_b.rd         = 3'b110;
    exp_b.imm        = 6'h15;
    tick();
    check_bundle("mixed", exp_b);

    // Priority: rst+flush, then flush alone, then load
    in_b  = '1;
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    check_bundle("rst_and_flush", '0);
    rst = 1'b0;
    tick();
    check_bundle("flush_only", '0);
    flush = 1'b0;
    tick();
    check_bundle("after_priority", {BUNDLE_W{1'b1}});

    // Flush held for two edges gives two bubbles
    flush = 1'b1;
    tick();
    check_bundle("flush_hold_1", '0);
    tick();
    check_bundle("flush_hold_2", '0);
    flush = 1'b0;
    in_b  = '0;

    // Streaming PC: each value appears exactly one edge later
    in_b.pc = 16'h0000;
    tick();
    check_pc("stream_0", 16'h0000);
    in_b.pc = 16'h0002;
    check_pc("stream_hold", 16'h0000);
    tick();
    check_pc("stream_2", 16'h0002);
    in_b.pc = 16'h0004;
    tick();
    check_pc("stream_4", 16'h0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
